// File: rtl/serial_byte_tx.sv
// Buffered serial byte transmitter: load-edge capture into a small FIFO, then
// 8N1 framing (start, 8 data LSB-first, stop), each bit held BIT_TICKS clocks.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (line low)
// DATA  | data bits, shift[0] on the line, LSB first
// STOP  | stop bit (line high); pops the next byte directly if one is queued
module serial_byte_tx #(
   parameter int DEPTH     = 4,
   parameter int BIT_TICKS = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] dataIn,
   output logic       serialOut,
   output logic       empty,
   output logic       full,
   output logic       busy,
   output logic       overflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
   localparam logic [PW:0]   DEPTH_C   = (PW+1)'(DEPTH);
   localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [TW-1:0] tick, tick_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shift, shift_n;
   logic          serial_n;
   logic          tick_end;

   logic          load_q;
   logic          wr, wr_ok, pop;
   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;

   assign wr    = load & ~load_q;
   assign wr_ok = wr && ((count < DEPTH_C) || pop);

   // load_q resets high so a load held through reset is not seen as an edge
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         load_q   <= 1'b1;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         load_q <= load;
         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (wr && !wr_ok)
            overflow <= 1'b1;
         case ({wr_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (wr_ok)
         mem[wr_ptr] <= dataIn;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         tick      <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         serialOut <= 1'b1;
      end else begin
         state     <= state_n;
         tick      <= tick_n;
         bit_idx   <= bit_n;
         shift     <= shift_n;
         serialOut <= serial_n;
      end
   end

   assign tick_end = (tick == TICK_LAST);

   always_comb begin
      state_n = state;
      tick_n  = tick + 1'b1;
      bit_n   = bit_idx;
      shift_n = shift;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            tick_n = '0;
            if (count != '0) begin
               pop     = 1'b1;
               shift_n = mem[rd_ptr];
               state_n = START;
            end
         end
         START: begin
            if (tick_end) begin
               tick_n  = '0;
               bit_n   = '0;
               state_n = DATA;
            end
         end
         DATA: begin
            if (tick_end) begin
               tick_n  = '0;
               shift_n = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7)
                  state_n = STOP;
               else
                  bit_n = bit_idx + 1'b1;
            end
         end
         STOP: begin
            if (tick_end) begin
               tick_n = '0;
               if (count != '0) begin
                  pop     = 1'b1;
                  shift_n = mem[rd_ptr];
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // line value follows the next state so it changes on the same edge
   always_comb begin
      serial_n = 1'b1;
      case (state_n)
         START:   serial_n = 1'b0;
         DATA:    serial_n = shift_n[0];
         default: serial_n = 1'b1;
      endcase
   end

   assign empty = (count == '0) && (state == IDLE);
   assign full  = (count == DEPTH_C);
   assign busy  = (state != IDLE);

endmodule
